// File: rtl/ysyx_24100029_axi_rom.sv
// AXI4 read-only ROM with sideband preload port; reads return the first beat LATENCY cycles after AR, then one beat per cycle.
// R beats hold under rready low; writes are accepted and discarded with SLVERR, B held until bready.
module ysyx_24100029_axi_rom #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          arvalid,
    output logic          arready,
    input  logic [31:0]   araddr,
    input  logic [3:0]    arid,
    input  logic [7:0]    arlen,
    input  logic [2:0]    arsize,
    input  logic [1:0]    arburst,
    output logic          rvalid,
    input  logic          rready,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    output logic          rlast,
    output logic [3:0]    rid,
    input  logic          awvalid,
    output logic          awready,
    input  logic [31:0]   awaddr,
    input  logic [3:0]    awid,
    input  logic [7:0]    awlen,
    input  logic [2:0]    awsize,
    input  logic [1:0]    awburst,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          wlast,
    output logic          bvalid,
    input  logic          bready,
    output logic [1:0]    bresp,
    output logic [3:0]    bid
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [3:0]  id_q;
    logic        fmt_err_q;
    logic [7:0]  beat_cnt;
    logic [7:0]  lat_cnt;
    logic [3:0]  bid_q;

    logic        ar_hs;
    logic        r_done;
    logic        present;
    logic [7:0]  nxt_beat;
    logic [31:0] nxt_addr;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] word;

    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = R_WAIT;
            R_WAIT:  if (lat_cnt == 8'd1) r_next = R_BURST;
            R_BURST: if (rready && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_BURST);
        ar_hs   = (r_state == R_IDLE) && arvalid;
        r_done  = (r_state == R_BURST) && rready && rlast;
        // A beat is loaded into the output registers when the wait expires or the current beat is taken.
        present = ((r_state == R_WAIT) && (lat_cnt == 8'd1))
               || ((r_state == R_BURST) && rready && !rlast);
    end

    assign nxt_beat = (r_state == R_BURST) ? beat_cnt + 8'd1 : 8'd0;
    assign nxt_addr = addr_q + {22'd0, nxt_beat, 2'b00};
    assign offset   = nxt_addr - BASE_ADDR;
    assign in_range = (nxt_addr >= BASE_ADDR) && (offset[31:2] < 30'(DEPTH_WORDS));
    assign idx      = offset[AW+1:2];
    // Forward a same-edge preload so the beat registered at this edge sees the new word.
    assign word     = (load_en && (load_addr == idx)) ? load_data : mem[idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            id_q      <= 4'd0;
            fmt_err_q <= 1'b0;
            beat_cnt  <= 8'd0;
            lat_cnt   <= 8'd0;
            rdata     <= 32'd0;
            rresp     <= 2'b00;
            rlast     <= 1'b0;
            rid       <= 4'd0;
        end else begin
            if (ar_hs) begin
                addr_q    <= araddr;
                len_q     <= arlen;
                id_q      <= arid;
                fmt_err_q <= (arsize != 3'b010) || (arburst != 2'b01);
                beat_cnt  <= 8'd0;
                lat_cnt   <= 8'(LATENCY);
            end else if (r_state == R_WAIT) begin
                lat_cnt <= lat_cnt - 8'd1;
            end
            if (present) begin
                beat_cnt <= nxt_beat;
                rid      <= id_q;
                rlast    <= (nxt_beat == len_q);
                if (fmt_err_q) begin
                    rresp <= 2'b10;
                    rdata <= 32'd0;
                end else if (in_range) begin
                    rresp <= 2'b00;
                    rdata <= word;
                end else begin
                    rresp <= 2'b11;
                    rdata <= 32'd0;
                end
            end else if (r_done) begin
                beat_cnt <= 8'd0;
                rdata    <= 32'd0;
                rresp    <= 2'b00;
                rlast    <= 1'b0;
                rid      <= 4'd0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_next = W_DATA;
            W_DATA:  if (wvalid && wlast) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state == W_IDLE);
        wready  = (w_state == W_DATA);
        bvalid  = (w_state == W_RESP);
        bresp   = (w_state == W_RESP) ? 2'b10 : 2'b00;
        bid     = (w_state == W_RESP) ? bid_q : 4'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bid_q <= 4'd0;
        end else if ((w_state == W_IDLE) && awvalid) begin
            bid_q <= awid;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{awaddr, awlen, awsize, awburst, wdata, wstrb, offset[1:0]};

endmodule

// File: tb/tb_ysyx_24100029_axi_rom.sv
// Directed bench for the AXI ROM: latency, bursts, stalls, error responses, writes, preload forwarding, reset.
module tb_ysyx_24100029_axi_rom;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_w [4];

    always #5 clock = ~clock;

    ysyx_24100029_axi_rom dut (
        .clock(clock), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (rvalid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 110000", {arready, awready, rvalid, rlast, wready, bvalid});
        end
        vectors++;
        if ({rdata, rresp, rid, bresp, bid} !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {rdata, rresp, rid, bresp, bid});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        rready = 1'b1;
        do_ar(BASE, 4'h3, 8'd3, 3'b010, 2'b01);
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_lat0: rvalid got %b expected 0", rvalid);
        end
        step();
        vectors++;
        if ({rvalid, arready} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_lat1: rvalid/arready got %b expected 00", {rvalid, arready});
        end
        step();
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if ({rvalid, rresp, rlast, rid, rdata} !== {1'b1, 2'b00, 1'(b == 3), 4'h3, exp_w[b]}) begin
                miscompares++;
                $display("FAIL basic_beat%0d: got %h expected %h", b, {rvalid, rresp, rlast, rid, rdata},
                         {1'b1, 2'b00, 1'(b == 3), 4'h3, exp_w[b]});
            end
            step();
        end
        vectors++;
        if ({rvalid, arready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_idle: rvalid/arready got %b expected 01", {rvalid, arready});
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat = 4'b1001;
        logic [39:0] held = '0;
        bit          held_vld = 1'b0;
        int          got = 0;
        rready = 1'b0;
        do_ar(BASE, 4'hA, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 40 && got < 4; i++) begin
            rready = pat[i % 4];
            if (held_vld) begin
                vectors++;
                if ({rvalid, rdata, rresp, rlast, rid} !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h expected %h", {rvalid, rdata, rresp, rlast, rid}, held);
                end
                held_vld = 1'b0;
            end
            if (rvalid) begin
                if (rready) begin
                    vectors++;
                    if ({rdata, rresp, rlast, rid} !== {exp_w[got], 2'b00, 1'(got == 3), 4'hA}) begin
                        miscompares++;
                        $display("FAIL stall_beat%0d: got %h expected %h", got, {rdata, rresp, rlast, rid},
                                 {exp_w[got], 2'b00, 1'(got == 3), 4'hA});
                    end
                    got++;
                end else begin
                    held = {rvalid, rdata, rresp, rlast, rid};
                    held_vld = 1'b1;
                end
            end
            step();
        end
        vectors++;
        if (got != 4 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_count: beats %0d rvalid %b expected 4 beats rvalid 0", got, rvalid);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] ed [4];
        logic [1:0]  er [4];
        bit ok;
        ed[0] = 32'hAAAA_0001; ed[1] = 32'hBBBB_0002; ed[2] = 32'd0; ed[3] = 32'd0;
        er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b11; er[3] = 2'b11;
        rready = 1'b1;
        do_ar(BASE + 32'hFF8, 4'h1, 8'd3, 3'b010, 2'b01);
        wait_rvalid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL decerr_timeout: rvalid got 0 expected 1");
        end
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if ({rvalid, rresp, rlast, rdata} !== {1'b1, er[b], 1'(b == 3), ed[b]}) begin
                miscompares++;
                $display("FAIL decerr_beat%0d: got %h expected %h", b, {rvalid, rresp, rlast, rdata},
                         {1'b1, er[b], 1'(b == 3), ed[b]});
            end
            step();
        end
    endtask

    task automatic test_slverr();
        bit ok;
        rready = 1'b1;
        do_ar(BASE, 4'h7, 8'd1, 3'b001, 2'b01);
        wait_rvalid(ok);
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (!ok || {rvalid, rresp, rlast, rid, rdata} !== {1'b1, 2'b10, 1'(b == 1), 4'h7, 32'd0}) begin
                miscompares++;
                $display("FAIL slverr_size_beat%0d: got %h expected %h", b, {rvalid, rresp, rlast, rid, rdata},
                         {1'b1, 2'b10, 1'(b == 1), 4'h7, 32'd0});
            end
            step();
        end
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL slverr_size_end: rvalid got %b expected 0", rvalid);
        end
        do_ar(BASE, 4'h2, 8'd0, 3'b010, 2'b10);
        wait_rvalid(ok);
        vectors++;
        if (!ok || {rresp, rlast, rid, rdata} !== {2'b10, 1'b1, 4'h2, 32'd0}) begin
            miscompares++;
            $display("FAIL slverr_burst: got %h expected %h", {rresp, rlast, rid, rdata}, {2'b10, 1'b1, 4'h2, 32'd0});
        end
        step();
    endtask

    task automatic test_write_concurrent();
        int wsent = 0;
        int got = 0;
        int bcycles = 0;
        bit ok;
        rready = 1'b1; bready = 1'b0;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awaddr = BASE; awid = 4'h5; awlen = 8'd3; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
        araddr = BASE; arid = 4'h9; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid) begin
                vectors++;
                if (bresp !== 2'b10 || bid !== 4'h5 || wsent != 4) begin
                    miscompares++;
                    $display("FAIL write_resp: bresp %b bid %h wbeats %0d expected 10 5 4", bresp, bid, wsent);
                end
                bcycles++;
                if (bcycles == 2) bready = 1'b1;
            end
            if (wready) begin
                wvalid = 1'b1; wlast = (wsent == 3); wsent++;
            end else begin
                wvalid = 1'b0; wlast = 1'b0;
            end
            if (rvalid) begin
                vectors++;
                if ({rdata, rresp, rlast, rid} !== {exp_w[got], 2'b00, 1'(got == 3), 4'h9}) begin
                    miscompares++;
                    $display("FAIL concur_beat%0d: got %h expected %h", got, {rdata, rresp, rlast, rid},
                             {exp_w[got], 2'b00, 1'(got == 3), 4'h9});
                end
                got++;
            end
            step();
        end
        vectors++;
        if (bcycles != 2 || got != 4 || {awready, wready, bvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL write_done: bcycles %0d rbeats %0d aw/w/b %b expected 2 4 100",
                     bcycles, got, {awready, wready, bvalid});
        end
        bready = 1'b0;
        do_ar(BASE, 4'h1, 8'd0, 3'b010, 2'b01);
        wait_rvalid(ok);
        vectors++;
        if (!ok || rdata !== exp_w[0]) begin
            miscompares++;
            $display("FAIL write_nochange: rdata got %h expected %h", rdata, exp_w[0]);
        end
        step();
    endtask

    task automatic test_load_bypass();
        bit ok;
        rready = 1'b1;
        do_ar(BASE, 4'h4, 8'd3, 3'b010, 2'b01);
        wait_rvalid(ok);
        step();
        vectors++;
        if (!ok || {rvalid, rdata} !== {1'b1, exp_w[1]}) begin
            miscompares++;
            $display("FAIL bypass_b1: got %h expected %h", {rvalid, rdata}, {1'b1, exp_w[1]});
        end
        load_en = 1'b1; load_addr = 10'd2; load_data = 32'h0000_0099;
        step();
        load_en = 1'b0;
        vectors++;
        if ({rvalid, rdata} !== {1'b1, 32'h0000_0099}) begin
            miscompares++;
            $display("FAIL bypass_b2: got %h expected %h", {rvalid, rdata}, {1'b1, 32'h0000_0099});
        end
        step();
        step();
        load_word(10'd2, exp_w[2]);
    endtask

    task automatic test_reset_mid();
        bit ok;
        rready = 1'b1;
        do_ar(BASE, 4'h6, 8'd7, 3'b010, 2'b01);
        wait_rvalid(ok);
        step();
        step();
        vectors++;
        if (!ok || {rvalid, rdata} !== {1'b1, exp_w[2]}) begin
            miscompares++;
            $display("FAIL rstmid_beat2: got %h expected %h", {rvalid, rdata}, {1'b1, exp_w[2]});
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({rvalid, arready, rlast, rdata, rresp, rid} !== {1'b0, 1'b1, 1'b0, 32'd0, 2'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h expected %h", {rvalid, arready, rlast, rdata, rresp, rid},
                     {1'b0, 1'b1, 1'b0, 32'd0, 2'd0, 4'd0});
        end
        step();
        reset = 1'b0;
        do_ar(BASE, 4'h8, 8'd3, 3'b010, 2'b01);
        vectors++;
        if (arready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_accept: arready got %b expected 0", arready);
        end
        wait_rvalid(ok);
        for (int b = 0; b < 4; b++) begin
            vectors++;
            if (!ok || {rvalid, rresp, rlast, rid, rdata} !== {1'b1, 2'b00, 1'(b == 3), 4'h8, exp_w[b]}) begin
                miscompares++;
                $display("FAIL rstmid_beat%0d: got %h expected %h", b, {rvalid, rresp, rlast, rid, rdata},
                         {1'b1, 2'b00, 1'(b == 3), 4'h8, exp_w[b]});
            end
            step();
        end
    endtask

    initial begin
        exp_w[0] = 32'd11; exp_w[1] = 32'd22; exp_w[2] = 32'd33; exp_w[3] = 32'd44;
        reset = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b0;
        step();
        step();
        test_reset();
        for (int i = 0; i < 4; i++) load_word(10'(i), exp_w[i]);
        load_word(10'd1022, 32'hAAAA_0001);
        load_word(10'd1023, 32'hBBBB_0002);
        test_basic();
        test_backpressure();
        test_decerr();
        test_slverr();
        test_write_concurrent();
        test_load_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
